regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the MIPS datapath.
- Provides NUM_RD combinational read ports and one byte-enabled write port, with optional write-to-read bypass.
- Holds a per-register busy scoreboard that the decode stage uses for load-use and multi-cycle hazard stalls.
- Sits between decode (reads, scoreboard set) and writeback (write, scoreboard clear).

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, register address width; depth is 2^ADDR_W.
- NUM_RD, 2, number of read ports, range 1..4.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return stored contents only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, same packing.
- rd_busy  out  NUM_RD  busy flag for each read port's register.
- we  in  1  write enable.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- wbe  in  DATA_W/8  byte enables; bit i covers wd[8i+7:8i].
- sb_set  in  1  mark sb_addr busy (producer issued).
- sb_addr  in  ADDR_W  scoreboard set address.
- sb_flush  in  1  clear all busy bits (pipeline flush).
- busy_cnt  out  ADDR_W+1  registered count of busy registers.

Behaviour:
- Reset (rst=0, asynchronous): all registers 0, all busy bits 0, busy_cnt 0. rd_data therefore reads 0 and rd_busy reads 0 while in reset. Release is synchronous to the next clk edge; the first write is accepted on the first rising edge with rst=1.
- Register 0: hardwired. Reads return 0, busy bit is always 0, writes to it are discarded, and sb_set to it is ignored.
- Write: at a rising edge with we=1 and wa!=0, byte i of regs[wa] takes wd byte i where wbe[i]=1; other bytes keep their value. we=1 with wbe all-zero changes no data but still clears busy.
- Read: combinational, zero latency, independent per port. Identical addresses on several ports return identical data.
- Bypass (BYPASS=1): if we=1, wa!=0 and rd_addr_k==wa, then rd_data_k = regs[wa] with wd merged in the enabled bytes, i.e. the value the register will hold after the edge. With BYPASS=0, the new value is visible from the cycle after the edge.
- Scoreboard next-state for register r!=0, in priority order:
  - sb_flush=1 -> 0. Flush overrides set and clear, but data writes still commit in that cycle.
  - else sb_set && sb_addr==r -> 1. Set wins over a simultaneous writeback clear to the same register, because a new producer was issued.
  - else we && wa==r -> 0.
  - else hold.
- rd_busy_k:
  - BYPASS=1: busy[rd_addr_k] AND NOT (we && wa==rd_addr_k).
  - BYPASS=0: busy[rd_addr_k].
  - Always 0 for address 0.
  - sb_set in the current cycle does not affect rd_busy until the next cycle.
- busy_cnt: registered popcount of the busy vector, equal to the number of busy bits after each edge. Range 0..2^ADDR_W-1 (register 0 is never busy). It changes by at most +1/-1 per cycle except on flush, when it goes to 0.
- No illegal states. Behaviour on X inputs is undefined.

Test Plan:
- Reset mid-operation: write regs[5]=0xDEADBEEF, set busy[5], assert rst low between edges -> rd_data for address 5 reads 0 and rd_busy=0 immediately (asynchronous), busy_cnt=0.
- Register 0: we=1, wa=0, wd=0xFFFFFFFF, plus sb_set with sb_addr=0 -> reads of address 0 stay 0, rd_busy=0, busy_cnt unchanged.
- Byte enables and bypass: regs[3]=0x11223344; write wd=0xAABBCCDD with wbe=4'b0101 while reading address 3 on both ports -> same-cycle rd_data=0x11BB33DD (BYPASS=1) or 0x11223344 (BYPASS=0); next cycle 0x11BB33DD for both settings.
- Scoreboard life cycle:
  - sb_set with sb_addr=7 -> next cycle rd_busy=1 on a port reading address 7, busy_cnt=1.
  - Writeback we=1, wa=7 -> same cycle rd_busy=0 (BYPASS=1); busy_cnt=0 after the edge.
- Simultaneous events on register 9 (busy): sb_set with sb_addr=9 plus we=1, wa=9 -> after the edge busy[9]=1 and the data is written. Repeat with sb_flush=1 -> busy[9]=0, busy_cnt=0, and the data is still written.
- Full scoreboard: set registers 1..31 on consecutive cycles -> busy_cnt counts 1..31 and never sets register 0; one flush cycle -> busy_cnt=0. Run with NUM_RD=4 and with ADDR_W=3 (busy_cnt saturates its range at 7).

Source files
------------

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb -- general-purpose register file with busy scoreboard
//
// Purpose:
//   Register file for the MIPS datapath. It has NUM_RD combinational read
//   ports and one byte-enabled write port. An optional write-to-read bypass
//   forwards same-cycle writes to the readers. A per-register busy scoreboard
//   lets decode stall on load-use and multi-cycle hazards: decode sets a
//   register busy, and writeback or a pipeline flush clears it.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   rd_addr   in   NUM_RD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   out  NUM_RD packed read data, port k at [k*DATA_W +: DATA_W]
//   rd_busy   out  busy flag of each read port's register
//   we        in   write enable
//   wa        in   write address
//   wd        in   write data
//   wbe       in   byte enables, bit i covers wd[8i+7:8i]
//   sb_set    in   mark sb_addr busy
//   sb_addr   in   scoreboard set address
//   sb_flush  in   clear every busy bit
//   busy_cnt  out  registered count of busy registers
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  input  logic [DATA_W/8-1:0]        wbe,
  input  logic                       sb_set,
  input  logic [ADDR_W-1:0]          sb_addr,
  input  logic                       sb_flush,
  output logic [ADDR_W:0]            busy_cnt
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   busy_cnt_q;
  logic [ADDR_W:0]   busy_cnt_d;

  logic              wr_fire;
  logic [DATA_W-1:0] wr_merged;

  // A write to register 0 is dropped entirely. Gating with rst keeps the
  // bypass path from showing wd while the file is held in reset.
  assign wr_fire = we && (wa != '0) && rst;

  // Value regs[wa] will hold after the edge: enabled bytes from wd, the
  // rest from the current contents. Shared by the write and the bypass.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_merge
      assign wr_merged[gi*8 +: 8] = wbe[gi] ? wd[gi*8 +: 8] : regs_q[wa][gi*8 +: 8];
    end
  endgenerate

  // Register storage. Entry 0 is never written, so it stays 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_fire) begin
      regs_q[wa] <= wr_merged;
    end
  end

  // Scoreboard next state. Flush beats everything. Otherwise a set beats a
  // writeback clear to the same register, because a newer producer has
  // been issued. The writeback clear goes first so the set can override it.
  always_comb begin
    busy_d = busy_q;
    if (sb_flush) begin
      busy_d = '0;
    end else begin
      if (wr_fire) begin
        busy_d[wa] = 1'b0;
      end
      if (sb_set && (sb_addr != '0)) begin
        busy_d[sb_addr] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;

    // The count is taken from the next-state vector, so the registered
    // count always matches the busy bits after the same edge.
    busy_cnt_d = '0;
    for (int r = 1; r < DEPTH; r++) begin
      busy_cnt_d = busy_cnt_d + (ADDR_W+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Read ports: combinational and independent of each other.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              hit;

      assign ra  = rd_addr[gi*ADDR_W +: ADDR_W];
      // wr_fire already excludes register 0, so a hit never targets it.
      assign hit = (BYPASS != 0) && wr_fire && (wa == ra);

      assign rd_data[gi*DATA_W +: DATA_W] = (ra == '0) ? '0 :
                                            hit        ? wr_merged :
                                                         regs_q[ra];
      // busy_q[0] is constant 0, so address 0 never reports busy. A
      // writeback in flight counts as not busy once it is forwarded.
      assign rd_busy[gi] = busy_q[ra] && !hit;
    end
  endgenerate

endmodule
